if_fetch_unit: RTL and testbench

Instruction-fetch stage that produces the F-side inputs of the IF/ID pipeline register: `F_ins`, `F_PC` and the slot-valid flag `F_lat`. It owns the PC register and drives a synchronous instruction memory with 1-cycle read latency. It honours the `pause` stall shared with IF/ID, and it takes branch/jump redirects resolved in D. It also flags misaligned or out-of-range fetch addresses.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/if_fetch_unit_if.sv | 38 +++
 rtl/if_fetch_unit_pc_gen.sv | 46 ++++
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Purpose : shared CPU constants (reset PC, imem map, NOP) and the fetch-address check.
// Latency : n/a (package, no logic state).
// Backpress: n/a.
//
// Contents:
//   PC_RESET, IMEM_BASE, IMEM_AW, IMEM_WORDS, NOP
//   fetch_addr_err() - misaligned / outside-imem test for a fetch byte address
package cpu_pkg;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
   localparam int          IMEM_AW    = 12;
   localparam int          IMEM_WORDS = 1 << IMEM_AW;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   // True when pc is not word aligned or lies outside
   // [base, base + 4*2^aw - 4]. The upper bound is formed in 33 bits so a
   // window touching the top of the address space does not wrap.
   function automatic logic fetch_addr_err(input logic [31:0] pc,
                                           input logic [31:0] base,
                                           input int          aw);
      logic [32:0] last;
      last = {1'b0, base} + (33'd1 << (aw + 2)) - 33'd4;
      return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} > last);
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Purpose : bundle between the fetch unit, its imem, the hazard/redirect
//           sources in D and the F side of the IF/ID register.
// Latency : n/a (wires only).
// Backpress: pause is the only stall; it freezes the fetch unit and IF/ID together.
//
// Signals:
//   pause, redirect, redirect_pc   control into the fetch unit
//   imem_en, imem_addr, imem_rdata synchronous imem read port (1-cycle latency)
//   F_ins, F_PC, F_lat, F_adel     F-side slot handed to IF/ID
// Modports: master = fetch unit, slave = everything around it.
interface if_fetch_unit_if #(
   parameter int IMEM_AW = 12
) ();

   logic               pause;
   logic               redirect;
   logic [31:0]        redirect_pc;

   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;

   logic [31:0]        F_ins;
   logic [31:0]        F_PC;
   logic               F_lat;
   logic               F_adel;

   modport master (
      input  pause, redirect, redirect_pc, imem_rdata,
      output imem_en, imem_addr, F_ins, F_PC, F_lat, F_adel
   );

   modport slave (
      output pause, redirect, redirect_pc, imem_rdata,
      input  imem_en, imem_addr, F_ins, F_PC, F_lat, F_adel
   );

endinterface

// File: rtl/if_fetch_unit_pc_gen.sv
// Purpose : request-PC register with +4 / redirect next-PC selection.
// Latency : next PC visible one clk edge after the decision.
// Backpress: pause freezes pc_q and drops any redirect presented with it.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pause               stall; holds pc_q
//   redirect/_pc        taken branch/jump from D and its byte target
//   pc_q                current request PC (drives imem address)
module pc_gen
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pause,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_q
);

   logic [31:0] pc_d;

   // A redirect seen under pause is dropped rather than remembered: D is
   // frozen too, so the hazard unit presents it again once D moves.
   always_comb begin
      pc_d = pc_q;
      if (!pause) begin
         if (redirect) begin
            pc_d = redirect_pc;
         end else begin
            pc_d = pc_q + 32'd4;   // wraps modulo 2^32
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose : instruction fetch stage producing F_ins/F_PC/F_lat/F_adel for IF/ID.
// Latency : 1 cycle from request PC to F_ins; 1 bubble after a taken redirect.
// Backpress: pause holds the F slot steady and captures imem data into a hold register.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus (master) pause/redirect/redirect_pc in, imem read port, F-side slot out
//
// The response side (rsp_*) describes the instruction whose imem data is
// arriving this cycle. Under pause the imem is not re-read, so a
// non-holding memory's output turns to garbage after the first stalled
// cycle; hold_ins keeps the word captured on that first cycle.
module if_fetch_unit #(
   parameter logic [31:0] PC_RESET  = cpu_pkg::PC_RESET,
   parameter logic [31:0] IMEM_BASE = cpu_pkg::IMEM_BASE,
   parameter int          IMEM_AW   = cpu_pkg::IMEM_AW
) (
   input  logic               clk,
   input  logic               reset,
   if_fetch_unit_if.master    bus
);

   import cpu_pkg::*;

   logic [31:0] pc_q;

   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_pc_q,    rsp_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_ins_q,  hold_ins_d;

   logic [31:0] imem_off;
   logic        slot_lat;
   logic        slot_adel;
   logic [31:0] slot_raw;

   pc_gen #(
      .PC_RESET (PC_RESET)
   ) u_pc_gen (
      .clk         (clk),
      .reset       (reset),
      .pause       (bus.pause),
      .redirect    (bus.redirect),
      .redirect_pc (bus.redirect_pc),
      .pc_q        (pc_q)
   );

   // Out-of-range PCs are still issued using the truncated offset; their
   // data never reaches F_ins because F_adel forces it to NOP.
   assign imem_off      = pc_q - IMEM_BASE;
   assign bus.imem_addr = IMEM_AW'(imem_off >> 2);
   assign bus.imem_en   = !bus.pause && !reset;

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_pc_d     = rsp_pc_q;
      hold_valid_d = hold_valid_q;
      hold_ins_d   = hold_ins_q;
      if (bus.pause) begin
         // Only the first stalled cycle carries the real imem word.
         if (!hold_valid_q) begin
            hold_ins_d   = bus.imem_rdata;
            hold_valid_d = 1'b1;
         end
      end else begin
         rsp_pc_d     = pc_q;
         // A redirect squashes the read now in flight (branch+8); the delay
         // slot currently in F is taken by IF/ID on this same edge.
         rsp_valid_d  = !bus.redirect;
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_pc_q     <= 32'h0;
         hold_valid_q <= 1'b0;
         hold_ins_q   <= 32'h0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_pc_q     <= rsp_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_ins_q   <= hold_ins_d;
      end
   end

   // Outputs are gated by reset so IF/ID sees an empty slot for the whole
   // reset window, not just after the first reset edge.
   assign slot_lat  = rsp_valid_q && !reset;
   assign slot_adel = slot_lat && fetch_addr_err(rsp_pc_q, IMEM_BASE, IMEM_AW);
   assign slot_raw  = hold_valid_q ? hold_ins_q : bus.imem_rdata;

   assign bus.F_lat  = slot_lat;
   assign bus.F_adel = slot_adel;
   assign bus.F_PC   = reset ? 32'h0 : rsp_pc_q;
   assign bus.F_ins  = (!slot_lat || slot_adel) ? NOP : slot_raw;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam logic [31:0] LAST = 32'h0000_6FFC;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   if_fetch_unit_if #(.IMEM_AW(12)) bus ();

   if_fetch_unit #(
      .PC_RESET  (32'h0000_3000),
      .IMEM_BASE (32'h0000_3000),
      .IMEM_AW   (12)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous imem; returns garbage whenever it is not enabled.
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
      else             bus.imem_rdata <= $urandom;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - BASE;
      return mem[off[13:2]];
   endfunction

   function automatic bit bad(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < BASE) || (pc > LAST);
   endfunction

   typedef struct {
      bit          rst;
      bit          p;
      bit          r;
      logic [31:0] rpc;
      bit          lat;
      logic [31:0] pc;
      bit          adel;
      logic [31:0] ins;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit rst, input bit p, input bit r, input logic [31:0] rpc,
                               input bit lat, input logic [31:0] pc, input bit adel,
                               input logic [31:0] ins);
      vec_t v;
      v.rst = rst; v.p = p; v.r = r; v.rpc = rpc;
      v.lat = lat; v.pc = pc; v.adel = adel; v.ins = ins;
      vecs.push_back(v);
   endfunction

   // Row helpers: each row is one cycle of inputs plus the F slot expected after the edge.
   function automatic void rst_row(input bit p);
      add(1, p, 0, 32'h0, 0, 32'h0, 0, 32'h0);
   endfunction
   function automatic void adv(input logic [31:0] pc);
      add(0, 0, 0, 32'h0, 1, pc, 0, word(pc));
   endfunction
   function automatic void adv_bad(input logic [31:0] pc);
      add(0, 0, 0, 32'h0, 1, pc, 1, 32'h0);
   endfunction
   function automatic void bub(input logic [31:0] rpc);
      add(0, 0, 1, rpc, 0, 32'h0, 0, 32'h0);
   endfunction
   function automatic void stl(input logic [31:0] pc, input bit r, input logic [31:0] rpc);
      add(0, 1, r, rpc, 1, pc, 0, word(pc));
   endfunction

   task automatic drive(input bit rst, input bit p, input bit r, input logic [31:0] rpc);
      reset           = rst;
      bus.pause       = p;
      bus.redirect    = r;
      bus.redirect_pc = rpc;
   endtask

   // Reference model state: next fetch address and the slot currently in F.
   logic [31:0] m_pc;
   logic [31:0] m_spc;
   bit          m_vld;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0001 + i * 32'h0001_0003;
      drive(1, 0, 0, 32'h0);

      // free run
      rst_row(0); rst_row(0);
      adv(32'h3000); adv(32'h3004); adv(32'h3008); adv(32'h300C);
      // redirect with delay slot 3004
      rst_row(0);
      adv(32'h3000); adv(32'h3004); bub(32'h3100); adv(32'h3100); adv(32'h3104);
      // 3-cycle stall at 3008
      rst_row(0);
      adv(32'h3000); adv(32'h3004); adv(32'h3008);
      stl(32'h3008, 0, 0); stl(32'h3008, 0, 0); stl(32'h3008, 0, 0);
      adv(32'h300C); adv(32'h3010);
      // pause + redirect together, then re-asserted on release
      stl(32'h3010, 1, 32'h3100); adv(32'h3014); adv(32'h3018);
      stl(32'h3018, 1, 32'h3200); bub(32'h3200); adv(32'h3200); adv(32'h3204);
      // address errors, back-to-back redirects, imem window edges
      bub(32'h3002); adv_bad(32'h3002); adv_bad(32'h3006);
      bub(32'h7000); adv_bad(32'h7000);
      bub(32'h3300); bub(32'h3400); adv(32'h3400); adv(32'h3404);
      bub(32'h6FFC); adv(32'h6FFC); adv_bad(32'h7000);
      bub(32'h2FFC); adv_bad(32'h2FFC); adv(32'h3000);
      // reset in the middle of a stall with hold already captured
      rst_row(0);
      adv(32'h3000); adv(32'h3004); stl(32'h3004, 0, 0); stl(32'h3004, 0, 0);
      rst_row(1); rst_row(0); adv(32'h3000); adv(32'h3004);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].p, vecs[i].r, vecs[i].rpc);
         @(posedge clk);
         @(negedge clk);
         chk("vec_F_lat",  i, {31'b0, bus.F_lat},  {31'b0, vecs[i].lat});
         chk("vec_F_adel", i, {31'b0, bus.F_adel}, {31'b0, vecs[i].adel});
         chk("vec_F_ins",  i, bus.F_ins, vecs[i].ins);
         if (vecs[i].lat || vecs[i].rst) chk("vec_F_PC", i, bus.F_PC, vecs[i].pc);
         if (vecs[i].rst) chk("vec_imem_en", i, {31'b0, bus.imem_en}, 32'h0);
      end

      // randomized run against the reference model
      for (int n = 0; n < 3000; n++) begin
         bit          rst, p, r;
         logic [31:0] rpc;
         bit          e_lat, e_adel;
         logic [31:0] e_ins, e_addr;
         int unsigned sel;
         rst = (n < 2) || ($urandom_range(0, 99) == 0);
         p   = ($urandom_range(0, 9) < 3);
         r   = ($urandom_range(0, 6) == 0);
         sel = $urandom_range(0, 9);
         case (sel)
            0:       rpc = $urandom;
            1:       rpc = BASE + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
            2:       rpc = LAST - 4 * $urandom_range(0, 1);
            3:       rpc = BASE - 4;
            default: rpc = BASE + 4 * $urandom_range(0, 4095);
         endcase
         drive(rst, p, r, rpc);
         @(posedge clk);
         if (rst) begin
            m_pc  = BASE;
            m_vld = 0;
         end else if (!p) begin
            m_spc = m_pc;
            m_vld = !r;
            m_pc  = r ? rpc : m_pc + 32'd4;
         end
         @(negedge clk);
         e_lat  = m_vld && !rst;
         e_adel = e_lat && bad(m_spc);
         e_ins  = (e_lat && !e_adel) ? word(m_spc) : 32'h0;
         e_addr = ((m_pc - BASE) >> 2) & 32'h0000_0FFF;
         chk("rnd_F_lat",  n, {31'b0, bus.F_lat},  {31'b0, e_lat});
         chk("rnd_F_adel", n, {31'b0, bus.F_adel}, {31'b0, e_adel});
         chk("rnd_F_ins",  n, bus.F_ins, e_ins);
         if (e_lat)     chk("rnd_F_PC", n, bus.F_PC, m_spc);
         else if (rst)  chk("rnd_F_PC", n, bus.F_PC, 32'h0);
         chk("rnd_imem_en",   n, {31'b0, bus.imem_en}, {31'b0, (!p && !rst)});
         chk("rnd_imem_addr", n, {20'b0, bus.imem_addr}, e_addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
